mem_arbiter: RTL

Single-port access controller for the shared 2048-word instruction/data/node block memory. It arbitrates three requesters onto the one memory port: instruction fetch, data load/store, and a 16-word node burst loader. The node burst reads 16 contiguous nodes into a local buffer for the neural-net datapath. The block sits between the core/datapath and the synchronous-read memory array.

---
 rtl/mem_arbiter_if.sv | 53 +++++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Requester, node-burst and memory-port signals of the shared block-memory arbiter.
// slave is the arbiter's view; master is the requesters' and memory's view.
interface mem_arbiter_if #(
    parameter int NODES = 16,
    parameter int AW    = 11
);
    logic                  iInstReq;
    logic [15:0]           iInstAddr;
    logic                  oInstGnt;
    logic                  oInstValid;
    logic [15:0]           oInstr;

    logic                  iDataReq;
    logic                  iDataWrite;
    logic [15:0]           iDataAddr;
    logic [15:0]           iData;
    logic                  oDataGnt;
    logic                  oDataValid;
    logic [15:0]           oData;

    logic                  iNodeStart;
    logic [15:0]           iNodeAddr;
    logic                  oNodeBusy;
    logic                  oNodeDone;
    logic [16*NODES-1:0]   oNodes;

    logic [AW-1:0]         oMemAddr;
    logic                  oMemWe;
    logic [15:0]           oMemWdata;
    logic [15:0]           iMemRdata;

    modport slave (
        input  iInstReq, iInstAddr,
        output oInstGnt, oInstValid, oInstr,
        input  iDataReq, iDataWrite, iDataAddr, iData,
        output oDataGnt, oDataValid, oData,
        input  iNodeStart, iNodeAddr,
        output oNodeBusy, oNodeDone, oNodes,
        output oMemAddr, oMemWe, oMemWdata,
        input  iMemRdata
    );

    modport master (
        output iInstReq, iInstAddr,
        input  oInstGnt, oInstValid, oInstr,
        output iDataReq, iDataWrite, iDataAddr, iData,
        input  oDataGnt, oDataValid, oData,
        output iNodeStart, iNodeAddr,
        input  oNodeBusy, oNodeDone, oNodes,
        input  oMemAddr, oMemWe, oMemWdata,
        output iMemRdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port arbiter for the shared block memory: data > node burst > instruction.
// The node burst loads NODES contiguous words (address wraps) into a local buffer.
module mem_arbiter #(
    parameter int NODES = 16,
    parameter int AW    = 11
) (
    input  logic         iclk,
    input  logic         irst,
    mem_arbiter_if.slave bus
);
    localparam int CW = $clog2(NODES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } node_state_t;

    node_state_t   r_state, w_state_next;
    logic [AW-1:0] r_base, w_base_next;
    logic [CW-1:0] r_issue_cnt, w_issue_cnt_next;
    logic          r_tag_valid, w_tag_valid_next;
    logic [CW-1:0] r_tag_idx, w_tag_idx_next;
    logic          r_inst_valid;
    logic          r_data_valid;

    logic          w_data_gnt;
    logic          w_node_issue;
    logic          w_inst_gnt;
    logic [AW-1:0] w_node_addr;
    logic          w_unused;

    assign w_unused = ^{bus.iInstAddr[15:AW], bus.iDataAddr[15:AW], bus.iNodeAddr[15:AW]};

    // A data request always wins; the burst simply holds its index for that cycle.
    assign w_data_gnt   = bus.iDataReq;
    assign w_node_issue = (r_state == S_FETCH) && !bus.iDataReq;
    assign w_inst_gnt   = bus.iInstReq && !bus.iDataReq && !w_node_issue;
    assign w_node_addr  = r_base + AW'(r_issue_cnt);

    always_comb begin
        bus.oMemAddr  = '0;
        bus.oMemWe    = 1'b0;
        bus.oMemWdata = '0;
        if (w_data_gnt) begin
            bus.oMemAddr  = bus.iDataAddr[AW-1:0];
            bus.oMemWe    = bus.iDataWrite;
            bus.oMemWdata = bus.iDataWrite ? bus.iData : 16'h0000;
        end else if (w_node_issue) begin
            bus.oMemAddr = w_node_addr;
        end else if (w_inst_gnt) begin
            bus.oMemAddr = bus.iInstAddr[AW-1:0];
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_base_next      = r_base;
        w_issue_cnt_next = r_issue_cnt;
        w_tag_valid_next = 1'b0;
        w_tag_idx_next   = r_tag_idx;
        case (r_state)
            S_IDLE: begin
                if (bus.iNodeStart) begin
                    w_state_next     = S_FETCH;
                    w_base_next      = bus.iNodeAddr[AW-1:0];
                    w_issue_cnt_next = '0;
                end
            end
            S_FETCH: begin
                if (w_node_issue) begin
                    w_tag_valid_next = 1'b1;
                    w_tag_idx_next   = r_issue_cnt;
                    if (r_issue_cnt == CW'(NODES - 1)) begin
                        w_state_next = S_DRAIN;
                    end else begin
                        w_issue_cnt_next = r_issue_cnt + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // The last tag is capturing its word this cycle.
                if (r_tag_valid) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_state      <= S_IDLE;
            r_base       <= '0;
            r_issue_cnt  <= '0;
            r_tag_valid  <= 1'b0;
            r_tag_idx    <= '0;
            r_inst_valid <= 1'b0;
            r_data_valid <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_base       <= w_base_next;
            r_issue_cnt  <= w_issue_cnt_next;
            r_tag_valid  <= w_tag_valid_next;
            r_tag_idx    <= w_tag_idx_next;
            r_inst_valid <= w_inst_gnt;
            r_data_valid <= w_data_gnt && !bus.iDataWrite;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NODES; gi++) begin : g_node
            logic [15:0] r_word;
            always_ff @(posedge iclk or posedge irst) begin
                if (irst) begin
                    r_word <= '0;
                end else if (r_tag_valid && (r_tag_idx == CW'(gi))) begin
                    r_word <= bus.iMemRdata;
                end
            end
            assign bus.oNodes[16*gi +: 16] = r_word;
        end
    endgenerate

    assign bus.oInstGnt   = w_inst_gnt;
    assign bus.oDataGnt   = w_data_gnt;
    assign bus.oInstValid = r_inst_valid;
    assign bus.oDataValid = r_data_valid;
    assign bus.oInstr     = r_inst_valid ? bus.iMemRdata : 16'h0000;
    assign bus.oData      = r_data_valid ? bus.iMemRdata : 16'h0000;
    assign bus.oNodeBusy  = (r_state != S_IDLE);
    assign bus.oNodeDone  = (r_state == S_DONE);
endmodule
